// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel control.
// Holds the controller state encoding and the default debounce length.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 200_000;

endpackage

// File: rtl/button_debounce.sv
// Raw button conditioning: 2-flop synchroniser, debounce counter and a
// registered one-cycle press pulse on each accepted 0->1 level change.
// Ports: clk, rst (sync, active-high), btn (raw), press (pulse out).
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Any agreeing cycle restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel control: debounced start/stop and clear buttons
// drive an IDLE/RUNNING/PAUSED FSM producing timer enable and BCD clear.
// Ports: clk, rst (sync, active-high), start_stop_btn, clear_btn (raw),
// enable, clear (1-cycle pulse), state[1:0], lap_hold (STOPWATCH_LAP_EN).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop_btn,
  input  logic       clear_btn,
  output logic       enable,
  output logic       clear,
`ifdef STOPWATCH_LAP_EN
  output logic       lap_hold,
`endif
  output logic [1:0] state
);

  logic   ss_p;
  logic   clr_p;
  state_t st_q;
  state_t st_d;
  logic   clear_d;
  logic   en_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ss (
    .clk  (clk),
    .rst  (rst),
    .btn  (start_stop_btn),
    .press(ss_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr (
    .clk  (clk),
    .rst  (rst),
    .btn  (clear_btn),
    .press(clr_p)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_d;
`endif

  // Outputs are registered from next-state so they move with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      enable <= 1'b0;
      clear  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_hold <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      enable <= en_d;
      clear  <= clear_d;
`ifdef STOPWATCH_LAP_EN
      lap_hold <= lap_d;
`endif
    end
  end

  // Clear beats start/stop when stopped; start/stop beats clear
  // while running.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (!clr_p && ss_p) st_d = RUNNING;
      end
      RUNNING: begin
        if (ss_p) st_d = PAUSED;
      end
      PAUSED: begin
        if (clr_p)     st_d = IDLE;
        else if (ss_p) st_d = RUNNING;
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    en_d    = (st_d == RUNNING);
    clear_d = clr_p && (st_q == IDLE || st_q == PAUSED);
`ifdef STOPWATCH_LAP_EN
    lap_d = lap_hold;
    if (st_q == RUNNING && clr_p && !ss_p) lap_d = ~lap_hold;
    if (st_d == IDLE) lap_d = 1'b0;
`endif
  end

  assign state = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4 (latency 8).
// Define STOPWATCH_LAP_EN to also exercise the lap_hold feature.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss  = 1'b0;
  logic       cb  = 1'b0;
  logic       enable;
  logic       clear;
  logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
  logic       lap_hold;
`endif

  int total   = 0;
  int bad     = 0;
  int pulses  = 0;
  int overlap = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_stop_btn(ss),
    .clear_btn     (cb),
    .enable        (enable),
    .clear         (clear),
`ifdef STOPWATCH_LAP_EN
    .lap_hold      (lap_hold),
`endif
    .state         (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clear === 1'b1) pulses++;
    if (clear === 1'b1 && enable === 1'b1) overlap++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic press(input string tag,
                       input logic s, input logic c,
                       input logic [1:0] pre,
                       input logic [1:0] post,
                       input int np, input logic lap_exp);
    int p0;
    p0 = pulses;
    @(negedge clk);
    ss = s;
    cb = c;
    repeat (7) @(negedge clk);
    chk({tag, ".pre_st"}, 32'(state), 32'(pre));
    chk({tag, ".pre_en"}, 32'(enable), 32'(pre == 2'd1));
    @(negedge clk);
    chk({tag, ".st"}, 32'(state), 32'(post));
    chk({tag, ".en"}, 32'(enable), 32'(post == 2'd1));
    chk({tag, ".clr"}, 32'(clear), 32'(np));
`ifdef STOPWATCH_LAP_EN
    chk({tag, ".lap"}, 32'(lap_hold), 32'(lap_exp));
`else
    if (lap_exp) begin end
`endif
    @(negedge clk);
    chk({tag, ".clr_off"}, 32'(clear), 32'd0);
    repeat (3) @(negedge clk);
    ss = 1'b0;
    cb = 1'b0;
    repeat (14) @(negedge clk);
    chk({tag, ".npulse"}, 32'(pulses - p0), 32'(np));
    chk({tag, ".hold_st"}, 32'(state), 32'(post));
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    ss  = 1'b1;
    cb  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.st", 32'(state), 32'd0);
    chk("rst.en", 32'(enable), 32'd0);
    chk("rst.clr", 32'(clear), 32'd0);
`ifdef STOPWATCH_LAP_EN
    chk("rst.lap", 32'(lap_hold), 32'd0);
`endif

    rst = 1'b0;
    cb  = 1'b0;
    repeat (7) @(negedge clk);
    chk("start.e7", 32'(enable), 32'd0);
    @(negedge clk);
    chk("start.e8", 32'(enable), 32'd1);
    chk("start.st", 32'(state), 32'd1);
    repeat (12) @(negedge clk);
    chk("start.held", 32'(enable), 32'd1);
    ss = 1'b0;
    repeat (14) @(negedge clk);
    chk("start.rel_st", 32'(state), 32'd1);
    chk("start.rel_en", 32'(enable), 32'd1);
    chk("start.noclr", 32'(pulses), 32'd0);

    press("runclr1", 1'b0, 1'b1, 2'd1, 2'd1, 0, 1'b1);
`ifdef STOPWATCH_LAP_EN
    press("runclr2", 1'b0, 1'b1, 2'd1, 2'd1, 0, 1'b0);
    press("runclr3", 1'b0, 1'b1, 2'd1, 2'd1, 0, 1'b1);
`endif
    press("pause", 1'b1, 1'b0, 2'd1, 2'd2, 0, 1'b1);
    press("pclr", 1'b0, 1'b1, 2'd2, 2'd0, 1, 1'b0);

    @(negedge clk);
    ss = 1'b1;
    repeat (3) @(negedge clk);
    ss = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch.st", 32'(state), 32'd0);
    chk("glitch.en", 32'(enable), 32'd0);

    press("start2", 1'b1, 1'b0, 2'd0, 2'd1, 0, 1'b0);
    press("sim_run", 1'b1, 1'b1, 2'd1, 2'd2, 0, 1'b0);
    press("sim_pau", 1'b1, 1'b1, 2'd2, 2'd0, 1, 1'b0);
    press("sim_idle", 1'b1, 1'b1, 2'd0, 2'd0, 1, 1'b0);

    p0 = pulses;
    @(negedge clk);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    ss  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst.st", 32'(state), 32'd0);
    chk("midrst.en", 32'(enable), 32'd0);
    chk("midrst.np", 32'(pulses - p0), 32'd0);

    @(negedge clk);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    chk("heldrst.e7", 32'(state), 32'd0);
    @(negedge clk);
    chk("heldrst.e8", 32'(state), 32'd1);
    chk("heldrst.en", 32'(enable), 32'd1);
    ss = 1'b0;
    repeat (14) @(negedge clk);

    chk("clr_en_overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
